sad_search_ctrl: RTL and testbench
==================================

// Module: sad_search_ctrl
// PURPOSE
//  Motion-search sequencer that sits above the SAD engine (controller + datapath).
//  It launches one SAD computation per candidate block, waits for each result and
//  tracks the minimum SAD and its candidate index.
//  It reports best match and completion to the host with a start/done handshake.
// PARAMETERS
//  NUM_CAND  16     number of candidate blocks per search (>=2)
//  SAD_W     16     SAD result width (256 px * 255 max = 65280 fits 16b)
//  IDX_W     4      candidate index width, = $clog2(NUM_CAND)
//  TIMEOUT   1024   max cycles in WAIT before declaring engine hang (>=1)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      host request: begin search (sampled in IDLE only)
//  sad_done   in   1      SAD engine result-valid pulse
//  sad_value  in   SAD_W  SAD result, valid when sad_done=1
//  sad_go     out  1      one-cycle launch pulse to SAD engine
//  cand_idx   out  IDX_W  candidate select to address generator; stable LAUNCH..CMP
//  busy       out  1      high from LAUNCH through FINISH
//  done       out  1      one-cycle pulse in FINISH
//  best_sad   out  SAD_W  minimum SAD of current/last search
//  best_idx   out  IDX_W  candidate index of best_sad
//  err        out  1      sticky timeout flag, cleared on next accepted start
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs and internal regs = 0.
//  FSM: IDLE -> LAUNCH -> WAIT -> CMP -> {LAUNCH | FINISH} -> IDLE.
//   IDLE:   start=1 -> LAUNCH; cand_idx<=0, first<=1, err<=0, best_sad<='1, best_idx<=0.
//   LAUNCH: sad_go=1 exactly this cycle; wait counter<=0; -> WAIT.
//   WAIT:   sad_done=1 -> capture sad_value into res_q, -> CMP.
//           else counter++; counter==TIMEOUT-1 -> err<=1, -> FINISH (result discarded).
//           sad_done and timeout in same cycle: sad_done wins.
//   CMP:    if first or res_q < best_sad: best_sad<=res_q, best_idx<=cand_idx; first<=0.
//           Ties (equal) keep earlier (lower) index.
//           cand_idx==NUM_CAND-1 -> FINISH; else cand_idx++ -> LAUNCH. No wrap.
//   FINISH: done=1 one cycle; -> IDLE. busy drops the following cycle.
//  Outputs sad_go, busy, done are state-decoded (Moore), no combinational input paths.
//  best_sad/best_idx hold after FINISH until next accepted start.
//  start while busy: ignored. sad_done outside WAIT: ignored (no capture).
//  Latency per candidate with engine latency L cycles (go->done): L+2 cycles.
//  Search total: NUM_CAND*(L+2) + 2 cycles start->done (incl. IDLE accept and FINISH).
//  Unused state encodings -> IDLE.
// STRUCTURE
//  Shared package sad_pkg: typedef enum logic [2:0] search_states
//   {IDLE, LAUNCH, WAIT, CMP, FINISH}; default constants SAD_W_DEF, NUM_CAND_DEF.
//  Sub-module sad_min_tracker: res_q/best_sad/best_idx regs, first flag, compare;
//   inputs init, cmp_en, res, idx. FSM, cand_idx counter and timeout counter in top.
// TESTING
//  1 Reset: rst=1 mid-WAIT at candidate 5 -> same cycle state IDLE, all outputs 0; no done.
//  2 Basic: NUM_CAND=4, L=3, SADs {40,25,30,60} -> best_sad=25, best_idx=1, done at
//    cycle 4*5+2=22 after start, 4 sad_go pulses, cand_idx 0..3.
//  3 Ties/first: SADs all 16'hFFFF -> best_sad=FFFF, best_idx=0;
//    SADs {9,7,7,8} -> best_idx=1.
//  4 Timeout: TIMEOUT=8, engine never asserts sad_done on cand 2 -> err=1 after 8 WAIT
//    cycles, done pulses, best reflects cand 0..1; next start clears err.
//  5 Protocol: start held high through search -> single search then restart once;
//    spurious sad_done in IDLE/CMP -> no state or best change.
//  6 Race: sad_done on exactly cycle counter==TIMEOUT-1 -> result accepted, err=0.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared types and default constants for the SAD motion-search sequencer.
package sad_pkg;

   localparam int unsigned SAD_W_DEF    = 16;
   localparam int unsigned NUM_CAND_DEF = 16;
   localparam int unsigned IDX_W_DEF    = $clog2(NUM_CAND_DEF);
   localparam int unsigned TIMEOUT_DEF  = 1024;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      CMP    = 3'd3,
      FINISH = 3'd4
   } search_states;

endpackage

// File: rtl/sad_search_ctrl_if.sv
// Host/engine-facing signal bundle of the search sequencer.
// master = host + SAD engine side, slave = sequencer side.
interface sad_search_ctrl_if #(
   parameter int unsigned SAD_W = sad_pkg::SAD_W_DEF,
   parameter int unsigned IDX_W = sad_pkg::IDX_W_DEF
);
   logic             start;
   logic             sad_done;
   logic [SAD_W-1:0] sad_value;
   logic             sad_go;
   logic [IDX_W-1:0] cand_idx;
   logic             busy;
   logic             done;
   logic [SAD_W-1:0] best_sad;
   logic [IDX_W-1:0] best_idx;
   logic             err;

   modport master (
      output start, sad_done, sad_value,
      input  sad_go, cand_idx, busy, done, best_sad, best_idx, err
   );

   modport slave (
      input  start, sad_done, sad_value,
      output sad_go, cand_idx, busy, done, best_sad, best_idx, err
   );
endinterface

// File: rtl/sad_min_tracker.sv
// Holds the latest SAD result and the running minimum with its candidate index.
// Strict less-than compare keeps the earliest index on ties.
module sad_min_tracker
   import sad_pkg::*;
#(
   parameter int unsigned SAD_W = SAD_W_DEF,
   parameter int unsigned IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_init,
   input  logic             i_cap,
   input  logic             i_cmp_en,
   input  logic [SAD_W-1:0] i_res,
   input  logic [IDX_W-1:0] i_idx,
   output logic [SAD_W-1:0] o_best_sad,
   output logic [IDX_W-1:0] o_best_idx
);

   logic [SAD_W-1:0] r_res_q;
   logic [SAD_W-1:0] r_best_sad;
   logic [IDX_W-1:0] r_best_idx;
   logic             r_first;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res_q    <= '0;
         r_best_sad <= '0;
         r_best_idx <= '0;
         r_first    <= 1'b0;
      end else begin
         if (i_init) begin
            r_best_sad <= '1;
            r_best_idx <= '0;
            r_first    <= 1'b1;
         end
         if (i_cap) begin
            r_res_q <= i_res;
         end
         if (i_cmp_en) begin
            if (r_first || (r_res_q < r_best_sad)) begin
               r_best_sad <= r_res_q;
               r_best_idx <= i_idx;
            end
            r_first <= 1'b0;
         end
      end
   end

   assign o_best_sad = r_best_sad;
   assign o_best_idx = r_best_idx;

endmodule

// File: rtl/sad_search_ctrl.sv
// Motion-search sequencer: launches one SAD job per candidate, waits with a
// hang timeout, and reports the minimum SAD and its index via start/done.
module sad_search_ctrl
   import sad_pkg::*;
#(
   parameter int unsigned NUM_CAND = NUM_CAND_DEF,
   parameter int unsigned SAD_W    = SAD_W_DEF,
   parameter int unsigned IDX_W    = $clog2(NUM_CAND),
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   sad_search_ctrl_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   search_states     r_state;
   logic [IDX_W-1:0] r_cand_idx;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_sad_go;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_init;
   logic             w_cap;
   logic             w_cmp_en;
   logic             w_last_cand;
   logic             w_timeout;

   assign w_init      = (r_state == IDLE) && bus.start;
   assign w_cap       = (r_state == WAIT) && bus.sad_done;
   assign w_cmp_en    = (r_state == CMP);
   assign w_last_cand = (r_cand_idx == IDX_W'(NUM_CAND - 1));
   assign w_timeout   = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

   // Moore outputs are registered by setting them on entry to their state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cand_idx <= '0;
         r_wait_cnt <= '0;
         r_sad_go   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_sad_go <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state    <= LAUNCH;
                  r_cand_idx <= '0;
                  r_err      <= 1'b0;
                  r_sad_go   <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            LAUNCH: begin
               r_wait_cnt <= '0;
               r_state    <= WAIT;
            end
            WAIT: begin
               // A result arriving on the final timeout cycle is still accepted.
               if (bus.sad_done) begin
                  r_state <= CMP;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= FINISH;
               end else begin
                  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
               end
            end
            CMP: begin
               if (w_last_cand) begin
                  r_done  <= 1'b1;
                  r_state <= FINISH;
               end else begin
                  r_cand_idx <= r_cand_idx + IDX_W'(1);
                  r_sad_go   <= 1'b1;
                  r_state    <= LAUNCH;
               end
            end
            FINISH: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   sad_min_tracker #(
      .SAD_W (SAD_W),
      .IDX_W (IDX_W)
   ) u_min_tracker (
      .clk        (clk),
      .rst        (rst),
      .i_init     (w_init),
      .i_cap      (w_cap),
      .i_cmp_en   (w_cmp_en),
      .i_res      (bus.sad_value),
      .i_idx      (r_cand_idx),
      .o_best_sad (bus.best_sad),
      .o_best_idx (bus.best_idx)
   );

   assign bus.sad_go   = r_sad_go;
   assign bus.cand_idx = r_cand_idx;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.err      = r_err;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Scoreboard bench for sad_search_ctrl: a behavioural SAD engine answers each
// launch from a per-candidate latency/value table; a monitor checks each done.
module tb_sad_search_ctrl;

   localparam int unsigned NC = 8;
   localparam int unsigned SW = 16;
   localparam int unsigned IW = 3;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sad_search_ctrl_if #(.SAD_W(SW), .IDX_W(IW)) bus();

   sad_search_ctrl #(
      .NUM_CAND (NC),
      .SAD_W    (SW),
      .IDX_W    (IW),
      .TIMEOUT  (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int sad;
      int idx;
      int err;
      int gos;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   lat_tab[NC];   // engine latency per candidate, 0 = never answers
   int   val_tab[NC];
   bit   dbl = 1'b0;    // repeat sad_done for one extra cycle (lands in CMP)
   bit   inj = 1'b0;    // request a single stray sad_done pulse

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // SAD engine model, driven on the falling edge.
   initial begin : engine
      int cnt;
      int pv;
      bit pend;
      bit extra;
      cnt = 0; pv = 0; pend = 1'b0; extra = 1'b0;
      bus.sad_done  = 1'b0;
      bus.sad_value = '0;
      forever begin
         @(negedge clk);
         bus.sad_done = 1'b0;
         if (rst) begin
            pend  = 1'b0;
            extra = 1'b0;
         end else begin
            if (extra) begin
               bus.sad_done = 1'b1; bus.sad_value = '0; extra = 1'b0;
            end
            if (inj) begin
               bus.sad_done = 1'b1; bus.sad_value = '0; inj = 1'b0;
            end
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  bus.sad_done  = 1'b1;
                  bus.sad_value = SW'(pv);
                  pend  = 1'b0;
                  extra = dbl;
               end
            end
            if (bus.sad_go === 1'b1 && lat_tab[bus.cand_idx] != 0) begin
               pend = 1'b1;
               cnt  = lat_tab[bus.cand_idx];
               pv   = val_tab[bus.cand_idx];
            end
         end
      end
   end

   // Monitor: checks launch order, and every done against the scoreboard.
   initial begin : monitor
      int   gos;
      int   cyc;
      bit   after;
      exp_t e;
      gos = 0; cyc = 0; after = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            gos = 0; cyc = 0; after = 1'b0;
         end else begin
            if (after) begin
               chk("busy_drop", 32'(bus.busy), 32'd0);
               after = 1'b0;
            end
            if (bus.sad_go === 1'b1) begin
               chk("cand_idx", 32'(bus.cand_idx), 32'(gos));
               gos++;
            end
            if (bus.busy === 1'b1) cyc++;
            if (bus.done === 1'b1) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got done with empty scoreboard");
               end else begin
                  e = sb.pop_front();
                  chk("best_sad", 32'(bus.best_sad), 32'(e.sad));
                  chk("best_idx", 32'(bus.best_idx), 32'(e.idx));
                  chk("err",      32'(bus.err),      32'(e.err));
                  chk("go_count", 32'(gos),          32'(e.gos));
                  chk("cycles",   32'(cyc + 1),      32'(e.cyc));
               end
               gos = 0; cyc = 0; after = 1'b1;
            end
         end
      end
   end

   task automatic wait_done(input int limit, input string name);
      int n = 0;
      while (bus.done !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (bus.done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: done not seen within %0d cycles", name, limit);
      end
   endtask

   task automatic do_search(input string name, input int s, input int i, input int e,
                            input int g, input int c);
      exp_t x;
      x.sad = s; x.idx = i; x.err = e; x.gos = g; x.cyc = c;
      sb.push_back(x);
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      chk({name, "_busy"},   32'(bus.busy), 32'd1);
      chk({name, "_errclr"}, 32'(bus.err),  32'd0);
      wait_done(400, name);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_sad_go"},   32'(bus.sad_go),   32'd0);
      chk({tag, "_cand_idx"}, 32'(bus.cand_idx), 32'd0);
      chk({tag, "_busy"},     32'(bus.busy),     32'd0);
      chk({tag, "_done"},     32'(bus.done),     32'd0);
      chk({tag, "_best_sad"}, 32'(bus.best_sad), 32'd0);
      chk({tag, "_best_idx"}, 32'(bus.best_idx), 32'd0);
      chk({tag, "_err"},      32'(bus.err),      32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      bus.start = 1'b0;
      lat_tab = '{3, 3, 3, 3, 3, 3, 3, 3};
      val_tab = '{40, 25, 30, 60, 45, 26, 25, 99};

      // Power-on reset state.
      repeat (2) @(negedge clk);
      chk_zero("por");
      rst = 1'b0;

      // Async reset while waiting on candidate 5: no done may follow.
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      n = 0;
      while (!(bus.sad_go === 1'b1 && bus.cand_idx == IW'(5)) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_cand5", 32'(bus.cand_idx), 32'd5);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Basic search; tie at index 6 must keep index 1.
      do_search("basic", 25, 1, 0, 8, 42);

      // All-maximum values: first candidate must still be recorded.
      lat_tab = '{1, 2, 3, 4, 1, 2, 3, 4};
      val_tab = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      do_search("allmax", 16'hFFFF, 0, 0, 8, 38);

      lat_tab = '{2, 2, 2, 2, 2, 2, 2, 2};
      val_tab = '{9, 7, 7, 8, 12, 7, 30, 8};
      do_search("ties", 7, 1, 0, 8, 34);

      // Engine hangs on candidate 2.
      lat_tab = '{3, 3, 0, 3, 3, 3, 3, 3};
      val_tab = '{50, 20, 5, 1, 1, 1, 1, 1};
      do_search("timeout", 20, 1, 1, 3, 21);

      // Start held high: exactly one restart after the first search.
      lat_tab = '{1, 1, 1, 1, 1, 1, 1, 1};
      val_tab = '{100, 90, 80, 70, 60, 50, 40, 30};
      begin
         exp_t x;
         x.sad = 30; x.idx = 7; x.err = 0; x.gos = 8; x.cyc = 26;
         sb.push_back(x);
         sb.push_back(x);
      end
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk);
      wait_done(400, "held_first");
      @(negedge clk);
      n = 0;
      while (bus.busy !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("held_restart", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      wait_done(400, "held_second");
      repeat (5) @(negedge clk);
      chk("held_no_third", 32'(bus.busy), 32'd0);

      // Stray sad_done in IDLE must not disturb the held result.
      inj = 1'b1;
      repeat (4) @(negedge clk);
      chk("spur_idle_sad", 32'(bus.best_sad), 32'd30);
      chk("spur_idle_idx", 32'(bus.best_idx), 32'd7);
      chk("spur_idle_busy", 32'(bus.busy), 32'd0);

      // Result on the last allowed WAIT cycle; extra done pulses land in CMP.
      dbl = 1'b1;
      lat_tab = '{8, 1, 1, 1, 8, 1, 1, 1};
      val_tab = '{500, 400, 300, 200, 100, 600, 700, 800};
      do_search("race", 100, 4, 0, 8, 40);
      dbl = 1'b0;

      repeat (5) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("final_err", 32'(bus.err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
